mem_lsu_store_buffer: RTL and testbench
=======================================

MEM_LSU_STORE_BUFFER -- requirements
Module: mem_lsu_store_buffer

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, store-buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 resets).
REQ-004 SHALL have port req_valid  input  1  MEM-stage access request.
REQ-005 SHALL have port req_we  input  1  1=store, 0=load.
REQ-006 SHALL have port req_size  input  2  0=byte, 1=half, 2=word; 3 illegal (treated as misaligned).
REQ-007 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-008 SHALL have port req_addr  input  32  full byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_ready  output  1  request accepted this cycle; pipeline stalls when 0.
REQ-011 SHALL have ports rdata/rdata_valid  output  32/1  load result, registered.
REQ-012 SHALL have port misalign  output  1  one-cycle pulse for a misaligned accepted request.
REQ-013 SHALL have port sb_empty  output  1  buffer empty and drain FSM idle.
REQ-014 SHALL have ports dm_w/dm_addr/dm_wdata  output  1/32/32  to the data memory (memory writes on falling edge, reads combinationally).
REQ-015 SHALL have port dm_rdata  input  32  data-memory combinational read data.

Function
REQ-016 SHALL be little-endian: addr[1:0]=0 selects bits 7:0.
REQ-017 Store accept: req_ready=!full; entry {word addr, data replicated per size, byte mask} pushed at tail; byte mask 1<<addr[1:0], half 0011/1100, word 1111.
REQ-018 Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size 3): req_ready=1, no push/no load, misalign=1 next cycle.
REQ-019 Load owns the DMEM port in its accept cycle (dm_addr=req_addr, dm_w=0); rdata/rdata_valid registered next cycle, sub-word extended per req_signed.
REQ-020 Load whose word address matches any valid entry SHALL stall (req_ready=0) until no match remains.
REQ-021 Drain FSM states IDLE, RD, WR: IDLE->WR if head mask=1111, IDLE->RD otherwise, RD->WR capturing dm_rdata merged under mask, WR->IDLE asserting dm_w=1 one cycle and popping head.
REQ-022 Drain FSM SHALL advance only in cycles where no load owns the port; otherwise holds state.
REQ-023 Push and pop in the same cycle SHALL keep count unchanged; pointers wrap modulo SB_DEPTH.
REQ-024 Store order to DMEM SHALL equal acceptance order.

Reset
REQ-025 On rst=0: buffer emptied, pointers/count 0, FSM IDLE, dm_w=0, rdata=0, rdata_valid=0, misalign=0, sb_empty=1; in-flight drain abandoned.
REQ-026 req_ready SHALL be 0 during the reset cycle.

Configuration
REQ-027 With STORE_FWD_EN defined: a matching load whose youngest matching entry has mask 1111 SHALL be served from that entry without stalling; extension rules per REQ-019.
REQ-028 Without STORE_FWD_EN: REQ-020 applies unconditionally.

Structure
REQ-029 Shared package SHALL hold size encodings, FSM state type, and the byte-mask/extension helper constants.
REQ-030 FIFO storage SHALL be one sub-module sb_fifo (push/pop/count/entry-compare vector); FSM and load path stay in the top.

Verification
REQ-031 sw 0x10010000 data 0xDEADBEEF, drain -> dm_w one cycle, dm_addr 0x10010000, dm_wdata 0xDEADBEEF, sb_empty=1 after.
REQ-032 Memory word 0x11223344, sb 0xAA to addr+2 -> RD then WR, dm_wdata 0x11AA3344; lb addr+2 signed -> 0xFFFFFFAA, lbu -> 0x000000AA.
REQ-033 SB_DEPTH=4, five back-to-back sw, loads blocking drain -> fifth sees req_ready=0 until first pop.
REQ-034 sw 0x12345678 then lw same address immediately -> without STORE_FWD_EN stall until drained then 0x12345678; with it, rdata_valid next cycle, 0x12345678.
REQ-035 lh addr 0x10010001 -> misalign pulse, no dm_w, no rdata_valid.
REQ-036 rst=0 during RD with two entries -> next cycle sb_empty=1, dm_w=0, no later write.

Source files
------------

// File: rtl/mem_lsu_store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: access-size encodings,
// drain FSM state type, buffer entry layout and the byte-mask / replication /
// merge / load-extension helpers used by both the buffer and the load path.
// Ports: none (package).
package mem_lsu_store_buffer_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  // Byte-lane masks (bit n enables bits 8n+7:8n, little-endian)
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_FULL    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [29:0] waddr;  // word address (byte address bits 31:2)
    logic [31:0] data;   // store data replicated into every lane of its size
    logic [3:0]  mask;   // lanes actually written
  } sb_entry_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = MASK_BYTE0 << off;
      SZ_HALF: m = off[1] ? MASK_HALF_HI : MASK_HALF_LO;
      default: m = MASK_FULL;
    endcase
    return m;
  endfunction

  // Replicating the data into every lane lets the drain merge purely by mask,
  // with no shifter on the write side.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{wdata[7:0]}};
      SZ_HALF: r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: r = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{16{sgn & sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_store_buffer_fifo.sv
// sb_fifo: circular store-buffer storage with per-slot word-address compare.
// Latency: push/pop take effect at the next rising edge; head/compare are combinational.
// Backpressure: none internally; the owner must not push when full or pop when empty.
// Ports: clk, rst (sync, active-low); i_push/i_push_entry, i_pop; i_cmp_waddr;
//        o_head, o_count, o_empty, o_match (per slot), o_fwd_hit/o_fwd_data
//        (youngest matching entry is a full-word store, and its data).
module sb_fifo
  import mem_lsu_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  sb_entry_t                i_push_entry,
  input  logic                     i_pop,
  input  logic [29:0]              i_cmp_waddr,
  output sb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic [DEPTH-1:0]         o_match,
  output logic                     o_fwd_hit,
  output logic [31:0]              o_fwd_data
);
  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [DEPTH-1:0] w_match;

  // Pop clears the head slot before push sets the tail; they never coincide
  // because a full buffer is never pushed.
  always_comb begin
    w_vld_nxt = r_vld;
    if (i_pop)  w_vld_nxt[r_head] = 1'b0;
    if (i_push) w_vld_nxt[r_tail] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: r_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_vld[i] && (r_mem[i].waddr == i_cmp_waddr);
    end
  end

  // Walk slots oldest-to-youngest from head so the last hit is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if (w_match[idx]) begin
        o_fwd_hit  = (r_mem[idx].mask == MASK_FULL);
        o_fwd_data = r_mem[idx].data;
      end
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_match = w_match;

endmodule

// File: rtl/mem_lsu_store_buffer.sv
// MEM-stage load/store unit with a posted store buffer draining to a single-port data memory.
// Latency: stores retire into the buffer in the accept cycle; load data is registered one cycle after accept.
// Backpressure: req_ready drops when the buffer is full (store) or a load hits a buffered word.
// Ports: clk, rst (sync, active-low); req_valid/req_we/req_size/req_signed/req_addr/req_wdata -> req_ready;
//        rdata/rdata_valid, misalign (pulse), sb_empty; dm_w/dm_addr/dm_wdata -> memory, dm_rdata <- memory.
// Build option: define STORE_FWD_EN to serve loads from the youngest matching full-word entry.
module mem_lsu_store_buffer
  import mem_lsu_store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        sb_empty,
  output logic        dm_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

`ifdef STORE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  drain_state_t     r_state;
  drain_state_t     w_state_nxt;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_rdata_valid;
  logic             r_misalign;

  logic [1:0]       w_off;
  logic             w_mis;
  logic             w_is_ld;
  logic             w_is_st;
  logic             w_hit;
  logic             w_fwd;
  logic             w_ld_stall;
  logic             w_acc;
  logic             w_push;
  logic             w_ld_acc;
  logic             w_ld_own;
  logic             w_mis_acc;
  logic             w_full;
  logic             w_pop;
  logic             w_cap_full;
  logic             w_cap_rd;
  logic             w_dm_w;
  logic [31:0]      w_ld_word;

  sb_entry_t        w_push_entry;
  sb_entry_t        w_head;
  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic [SB_DEPTH-1:0] w_match;
  logic             w_fwd_hit;
  logic [31:0]      w_fwd_data;

  // ---------------------------------------------------------------- request decode
  assign w_off   = req_addr[1:0];
  assign w_mis   = is_misaligned(req_size, w_off);
  assign w_is_ld = req_valid & ~req_we & ~w_mis;
  assign w_is_st = req_valid &  req_we & ~w_mis;
  assign w_hit   = |w_match;
  assign w_full  = (w_count == CW'(SB_DEPTH));

  // Forwarding only when the youngest matching entry covers the whole word;
  // anything narrower would need a merge with memory, so it stalls instead.
  assign w_fwd      = FWD_ON & w_is_ld & w_fwd_hit;
  assign w_ld_stall = w_is_ld & w_hit & ~w_fwd;

  always_comb begin
    req_ready = 1'b1;
    if (!rst) begin
      req_ready = 1'b0;
    end else if (req_valid && w_mis) begin
      req_ready = 1'b1;
    end else if (req_valid && req_we) begin
      req_ready = ~w_full;
    end else begin
      req_ready = ~w_ld_stall;
    end
  end

  assign w_acc     = req_valid & req_ready;
  assign w_push    = w_acc & w_is_st;
  assign w_ld_acc  = w_acc & w_is_ld;
  // A forwarded load never touches memory, so it leaves the port to the drain.
  assign w_ld_own  = w_ld_acc & ~w_fwd;
  assign w_mis_acc = w_acc & w_mis;

  assign w_push_entry = '{waddr: req_addr[31:2],
                          data:  replicate(req_size, req_wdata),
                          mask:  byte_mask(req_size, w_off)};

  sb_fifo #(
    .DEPTH (SB_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_cmp_waddr  (req_addr[31:2]),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_empty      (w_empty),
    .o_match      (w_match),
    .o_fwd_hit    (w_fwd_hit),
    .o_fwd_data   (w_fwd_data)
  );

  // ---------------------------------------------------------------- drain FSM
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cap_full  = 1'b0;
    w_cap_rd    = 1'b0;
    w_dm_w      = 1'b0;
    if (!w_ld_own) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (w_head.mask == MASK_FULL) begin
              w_state_nxt = ST_WR;
              w_cap_full  = 1'b1;
            end else begin
              w_state_nxt = ST_RD;
            end
          end
        end
        ST_RD: begin
          w_state_nxt = ST_WR;
          w_cap_rd    = 1'b1;
        end
        ST_WR: begin
          w_state_nxt = ST_IDLE;
          w_dm_w      = 1'b1;
          w_pop       = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- registered outputs
  assign w_ld_word = w_fwd ? w_fwd_data : dm_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_rdata_valid <= w_ld_acc;
      r_misalign    <= w_mis_acc;
      if (w_ld_acc) r_rdata <= load_extend(req_size, req_signed, w_off, w_ld_word);
      if (w_cap_full)    r_wdata <= w_head.data;
      else if (w_cap_rd) r_wdata <= merge_bytes(dm_rdata, w_head.data, w_head.mask);
    end
  end

  // ---------------------------------------------------------------- memory port
  assign dm_w        = w_dm_w & rst;
  assign dm_addr     = w_ld_own ? req_addr : {w_head.waddr, 2'b00};
  assign dm_wdata    = r_wdata;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign misalign    = r_misalign;
  assign sb_empty    = w_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_mem_lsu_store_buffer.sv
module tb_mem_lsu_store_buffer;
  import mem_lsu_store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        sb_empty;
  logic        dm_w;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  always #5 clk = ~clk;

  mem_lsu_store_buffer #(.SB_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .sb_empty    (sb_empty),
    .dm_w        (dm_w),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata)
  );

  // Data memory: combinational read, write on the falling edge.
  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign dm_rdata = mem[dm_addr[9:2]];

  always @(negedge clk) begin
    if (dm_w) begin
      mem[dm_addr[9:2]] <= dm_wdata;
      wr_cnt            <= wr_cnt + 1;
      last_wr_addr      <= dm_addr;
      last_wr_data      <= dm_wdata;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one request, hold it until accepted, then return at the negedge
  // of the following cycle where registered outputs can be observed.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, output int stalls);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    stalls = 0;
    @(negedge clk);
    while (!req_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: addr %h never accepted", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!sb_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, sb_empty}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_mis;
    logic        exp_vld;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int st;
    int wr0;
    int stalls[6];
    int rel_wr;
    string nm;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 32'h11223344;

    //            we    size     sg    addr          wdata         mis   vld   rdata
    tbl[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h10010000, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, SZ_BYTE, 1'b0, 32'h10010006, 32'h000000AA, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, SZ_BYTE, 1'b1, 32'h10010006, 32'h0,        1'b0, 1'b1, 32'hFFFFFFAA};
    tbl[3]  = '{1'b0, SZ_BYTE, 1'b0, 32'h10010006, 32'h0,        1'b0, 1'b1, 32'h000000AA};
    tbl[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h10010004, 32'h0,        1'b0, 1'b1, 32'h11AA3344};
    tbl[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h10010004, 32'h0,        1'b0, 1'b1, 32'h00003344};
    tbl[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h10010006, 32'h0,        1'b0, 1'b1, 32'h000011AA};
    tbl[7]  = '{1'b1, SZ_HALF, 1'b0, 32'h1001000A, 32'h00008001, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, SZ_HALF, 1'b1, 32'h1001000A, 32'h0,        1'b0, 1'b1, 32'hFFFF8001};
    tbl[9]  = '{1'b0, SZ_HALF, 1'b0, 32'h10010001, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b1, SZ_WORD, 1'b0, 32'h10010002, 32'h55555555, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b0, SZ_ILL,  1'b0, 32'h10010000, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, SZ_BYTE, 1'b0, 32'h10010003, 32'h0,        1'b0, 1'b1, 32'h000000DE};
    tbl[13] = '{1'b0, SZ_BYTE, 1'b1, 32'h10010001, 32'h0,        1'b0, 1'b1, 32'hFFFFFFBE};
    tbl[14] = '{1'b0, SZ_WORD, 1'b0, 32'h10010008, 32'h0,        1'b0, 1'b1, 32'h80010000};

    // ---------------- reset, with a store presented during reset
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h10010000; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    check("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_w", {31'b0, dm_w}, 32'd0);

    // ---------------- word store drains as a single write
    wr0 = wr_cnt;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10010000, 32'hDEADBEEF, st);
    check("sw_not_empty", {31'b0, sb_empty}, 32'd0);
    wait_empty("sw_drain_empty");
    #1;
    check("sw_write_count", wr_cnt - wr0, 32'd1);
    check("sw_write_addr", last_wr_addr, 32'h10010000);
    check("sw_write_data", last_wr_data, 32'hDEADBEEF);

    // ---------------- directed vector table
    for (int i = 0; i < 15; i++) begin
      do_req(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, st);
      $sformat(nm, "vec%0d_misalign", i);
      check(nm, {31'b0, misalign}, {31'b0, tbl[i].exp_mis});
      $sformat(nm, "vec%0d_rdata_valid", i);
      check(nm, {31'b0, rdata_valid}, {31'b0, tbl[i].exp_vld});
      if (tbl[i].exp_vld) begin
        $sformat(nm, "vec%0d_rdata", i);
        check(nm, rdata, tbl[i].exp_rdata);
      end
    end
    wait_empty("table_drain_empty");

    // ---------------- misaligned half load: single pulse, no write
    #1; wr0 = wr_cnt;
    do_req(1'b0, SZ_HALF, 1'b0, 32'h10010001, 32'h0, st);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_no_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    @(negedge clk);
    check("mis_pulse_one_cycle", {31'b0, misalign}, 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("mis_no_write", wr_cnt - wr0, 32'd0);

    // ---------------- store then immediate load to the same word
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h10010100; req_wdata = 32'h12345678;
    @(negedge clk);
    check("fwd_sw_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'h0;
    st = 0;
    @(negedge clk);
    while (!req_ready && st < 50) begin st++; @(negedge clk); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
`ifdef STORE_FWD_EN
    check("raw_stall_cycles", st, 32'd0);
`else
    check("raw_stall_cycles", st, 32'd2);
`endif
    check("raw_rdata_valid", {31'b0, rdata_valid}, 32'd1);
    check("raw_rdata", rdata, 32'h12345678);
    wait_empty("raw_drain_empty");

    // ---------------- back-to-back byte stores fill the buffer
    #1; wr0 = wr_cnt;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
      req_addr = 32'h10010040 + k; req_wdata = 32'(k + 1);
      st = 0;
      @(negedge clk);
      while (!req_ready && st < 50) begin st++; @(negedge clk); end
      stalls[k] = st;
      if (k == 5) begin
        #1; rel_wr = wr_cnt - wr0;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("full_early_stalls", stalls[0] + stalls[1] + stalls[2] + stalls[3] + stalls[4], 32'd0);
    check("full_sixth_stalls", stalls[5], 32'd2);
    check("full_release_after_pop", rel_wr, 32'd2);
    wait_empty("full_drain_empty");
    check("order_word16", mem[16], 32'h04030201);
    check("order_word17", mem[17], 32'h00000605);

    // ---------------- reset while draining with two entries buffered
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h10010080; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_addr = 32'h10010081; req_wdata = 32'h66;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    wr0 = wr_cnt;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sb_empty", {31'b0, sb_empty}, 32'd1);
    check("rst_mid_dm_w", {31'b0, dm_w}, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("rst_mid_no_write", wr_cnt - wr0, 32'd0);
    check("rst_mid_mem_untouched", mem[32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
